// File: rtl/regfile_writeback.sv
// Write-back queue for the 32x32 register file: accepts results, drains one write per cycle, flags pending hazards.
// Optional macro WB_BYPASS_EN adds rs/rt forwarding outputs (youngest matching write).
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     regWrite,
  input  logic                     regDest,
  input  logic [AW-1:0]            rt,
  input  logic [AW-1:0]            rd,
  input  logic [DW-1:0]            writeData,
  input  logic                     wr_stall,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            rs_q,
  input  logic [AW-1:0]            rt_q,
  output logic                     rs_pending,
  output logic                     rt_pending,
`ifdef WB_BYPASS_EN
  output logic                     rs_fwd_valid,
  output logic [DW-1:0]            rs_fwd_data,
  output logic                     rt_fwd_valid,
  output logic [DW-1:0]            rt_fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;

  logic [AW-1:0]    dest;
  logic             full;
  logic             push;
  logic             pop;

  assign dest     = regDest ? rd : rt;
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  // in_ready uses the pre-pop count, so a full queue never takes a same-cycle push
  assign push     = in_valid && !full && regWrite && (dest != '0) && !flush;
  assign pop      = !wr_stall && (count_q != '0) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (flush) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= pop;
      if (pop) begin
        wr_addr_q     <= addr_q[rptr_q];
        wr_data_q     <= data_q[rptr_q];
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
      if (push) begin
        addr_q[wptr_q] <= dest;
        data_q[wptr_q] <= writeData;
        vld_q[wptr_q]  <= 1'b1;
        wptr_q         <= wptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Output stage is oldest; walk the queue oldest->newest so the youngest match wins.
  always_comb begin
    idx          = '0;
    rs_fwd_valid = wr_en_q && (wr_addr_q == rs_q) && (rs_q != '0);
    rs_fwd_data  = rs_fwd_valid ? wr_data_q : '0;
    rt_fwd_valid = wr_en_q && (wr_addr_q == rt_q) && (rt_q != '0);
    rt_fwd_data  = rt_fwd_valid ? wr_data_q : '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if (vld_q[idx] && (addr_q[idx] == rs_q) && (rs_q != '0)) begin
        rs_fwd_valid = 1'b1;
        rs_fwd_data  = data_q[idx];
      end
      if (vld_q[idx] && (addr_q[idx] == rt_q) && (rt_q != '0)) begin
        rt_fwd_valid = 1'b1;
        rt_fwd_data  = data_q[idx];
      end
    end
  end

  assign rs_pending = 1'b0;
  assign rt_pending = 1'b0;
`else
  logic rs_hit, rt_hit;

  always_comb begin
    rs_hit = wr_en_q && (wr_addr_q == rs_q);
    rt_hit = wr_en_q && (wr_addr_q == rt_q);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[PW'(i)] && (addr_q[PW'(i)] == rs_q)) rs_hit = 1'b1;
      if (vld_q[PW'(i)] && (addr_q[PW'(i)] == rt_q)) rt_hit = 1'b1;
    end
  end

  assign rs_pending = rs_hit && (rs_q != '0);
  assign rt_pending = rt_hit && (rt_q != '0);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, async-reset check, and random traffic vs a queue model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, regWrite, regDest;
  logic [4:0]  rt, rd, rs_q, rt_q, wr_addr;
  logic [31:0] writeData, wr_data;
  logic        wr_stall, flush, wr_en, rs_pending, rt_pending;
  logic [2:0]  count;
`ifdef WB_BYPASS_EN
  logic        rs_fwd_valid, rt_fwd_valid;
  logic [31:0] rs_fwd_data, rt_fwd_data;
`endif

  regfile_writeback #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .regWrite(regWrite), .regDest(regDest), .rt(rt), .rd(rd), .writeData(writeData),
    .wr_stall(wr_stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_q(rs_q), .rt_q(rt_q), .rs_pending(rs_pending), .rt_pending(rt_pending),
`ifdef WB_BYPASS_EN
    .rs_fwd_valid(rs_fwd_valid), .rs_fwd_data(rs_fwd_data),
    .rt_fwd_valid(rt_fwd_valid), .rt_fwd_data(rt_fwd_data),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic vld, rw, rdst; logic [4:0] rt, rd; logic [31:0] data;
    logic stall, fl; logic [4:0] rsq, rtq;
    logic en; logic [4:0] addr; logic [31:0] wdata; logic [2:0] cnt;
    logic rdy, rsp, rtp;
  } vec_t;
  vec_t tbl[$];

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic vld, rw, rdst, input logic [4:0] r_t, r_d, input logic [31:0] dat,
                     input logic st, fl, input logic [4:0] rsq, rtq,
                     input logic en, input logic [4:0] addr, input logic [31:0] wd, input logic [2:0] cnt,
                     input logic rdy, rsp, rtp);
    vec_t v;
    v.vld = vld; v.rw = rw; v.rdst = rdst; v.rt = r_t; v.rd = r_d; v.data = dat;
    v.stall = st; v.fl = fl; v.rsq = rsq; v.rtq = rtq;
    v.en = en; v.addr = addr; v.wdata = wd; v.cnt = cnt; v.rdy = rdy; v.rsp = rsp; v.rtp = rtp;
    tbl.push_back(v);
  endtask

  function automatic logic exp_pend(input logic p);
`ifdef WB_BYPASS_EN
    return 1'b0;
`else
    return p;
`endif
  endfunction

  function automatic logic model_pend(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (m_en && m_addr == a) return 1'b1;
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Youngest matching write: newest queue entry first, then the output stage.
  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    if (a == 0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_en && m_addr == a) return {1'b1, m_data};
    return 33'd0;
  endfunction

  task automatic model_reset();
    mq.delete(); m_en = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    int sz;
    logic [4:0] dest;
    ent_t e;
    sz = mq.size();
    dest = regDest ? rd : rt;
    if (flush) begin
      mq.delete(); m_en = 1'b0;
    end else begin
      if (!wr_stall && sz > 0) begin
        e = mq.pop_front(); m_en = 1'b1; m_addr = e.a; m_data = e.d;
      end else m_en = 1'b0;
      if (in_valid && sz < DEPTH && regWrite && dest != 0) begin
        e.a = dest; e.d = writeData; mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; regWrite = 0; regDest = 0; rt = 0; rd = 0; writeData = 0;
    wr_stall = 0; flush = 0; rs_q = 0; rt_q = 0;
  endtask

  task automatic model_compare(input int c);
    logic [32:0] f;
    check("rnd_rdy", c, in_ready, mq.size() < DEPTH);
    check("rnd_cnt", c, count, mq.size());
    check("rnd_en", c, wr_en, m_en);
    if (m_en) begin
      check("rnd_addr", c, wr_addr, m_addr);
      check("rnd_data", c, wr_data, m_data);
    end
    check("rnd_rsp", c, rs_pending, exp_pend(model_pend(rs_q)));
    check("rnd_rtp", c, rt_pending, exp_pend(model_pend(rt_q)));
`ifdef WB_BYPASS_EN
    f = model_fwd(rs_q);
    check("rnd_rsfv", c, rs_fwd_valid, f[32]);
    if (f[32]) check("rnd_rsfd", c, rs_fwd_data, f[31:0]);
    f = model_fwd(rt_q);
    check("rnd_rtfv", c, rt_fwd_valid, f[32]);
    if (f[32]) check("rnd_rtfd", c, rt_fwd_data, f[31:0]);
`else
    f = 33'd0;
`endif
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #12;
    check("rst_en", 0, wr_en, 0);
    check("rst_cnt", 0, count, 0);
    check("rst_rdy", 0, in_ready, 1);
    check("rst_rsp", 0, rs_pending, 0);
    reset = 1'b0;

    // single write, latency, pending
    row(1,1,1, 0, 5, 32'hDEADBEEF, 0,0, 0, 5,  0, 0, 0,            1, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,0, 0, 5,  1, 5, 32'hDEADBEEF, 0, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,0, 0, 5,  0, 0, 0,            0, 1, 0, 0);
    // discards: dest $0 and regWrite=0
    row(1,1,0, 0, 9, 32'h1234,     0,0, 0, 0,  0, 0, 0,            0, 1, 0, 0);
    row(1,0,1, 0, 7, 32'h5678,     0,0, 0, 0,  0, 0, 0,            0, 1, 0, 0);
    row(0,0,0, 0, 0, 0,            0,0, 0, 0,  0, 0, 0,            0, 1, 0, 0);
    // fill under stall, refused push when full, then drain
    row(1,1,1, 0, 1, 32'h11,       1,0, 1, 4,  0, 0, 0,            1, 1, 1, 0);
    row(1,1,1, 0, 2, 32'h22,       1,0, 1, 4,  0, 0, 0,            2, 1, 1, 0);
    row(1,1,1, 0, 3, 32'h33,       1,0, 1, 4,  0, 0, 0,            3, 1, 1, 0);
    row(1,1,1, 0, 4, 32'h44,       1,0, 1, 4,  0, 0, 0,            4, 0, 1, 1);
    row(1,1,1, 0, 6, 32'h66,       1,0, 1, 6,  0, 0, 0,            4, 0, 1, 0);
    row(0,0,0, 0, 0, 0,            0,0, 1, 4,  1, 1, 32'h11,       3, 1, 1, 1);
    row(0,0,0, 0, 0, 0,            0,0, 1, 4,  1, 2, 32'h22,       2, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,0, 1, 4,  1, 3, 32'h33,       1, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,0, 1, 4,  1, 4, 32'h44,       0, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,0, 1, 4,  0, 0, 0,            0, 1, 0, 0);
    // same-register ordering
    row(1,1,1, 0, 9, 32'h1,        0,0, 9, 0,  0, 0, 0,            1, 1, 1, 0);
    row(1,1,1, 0, 9, 32'h2,        0,0, 9, 0,  1, 9, 32'h1,        1, 1, 1, 0);
    row(0,0,0, 0, 0, 0,            0,0, 9, 0,  1, 9, 32'h2,        0, 1, 1, 0);
    row(0,0,0, 0, 0, 0,            0,0, 9, 0,  0, 0, 0,            0, 1, 0, 0);
    // flush beats stall and a concurrent accept
    row(1,1,1, 0,10, 32'hA0,       1,0,10, 0,  0, 0, 0,            1, 1, 1, 0);
    row(1,1,1, 0,11, 32'hB0,       1,0,10, 0,  0, 0, 0,            2, 1, 1, 0);
    row(1,1,1, 0,12, 32'hC0,       1,0,10, 0,  0, 0, 0,            3, 1, 1, 0);
    row(1,1,1, 0,13, 32'hD0,       1,1,10,13,  0, 0, 0,            0, 1, 0, 0);
    row(0,0,0, 0, 0, 0,            0,0,10,13,  0, 0, 0,            0, 1, 0, 0);
    // flush kills an active output stage and a queued entry
    row(1,1,1, 0,14, 32'hE0,       0,0, 0,14,  0, 0, 0,            1, 1, 0, 1);
    row(1,1,1, 0,15, 32'hF0,       0,0, 0,14,  1,14, 32'hE0,       1, 1, 0, 1);
    row(0,0,0, 0, 0, 0,            0,1, 0,14,  0, 0, 0,            0, 1, 0, 0);

    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; regWrite = tbl[i].rw; regDest = tbl[i].rdst;
      rt = tbl[i].rt; rd = tbl[i].rd; writeData = tbl[i].data;
      wr_stall = tbl[i].stall; flush = tbl[i].fl; rs_q = tbl[i].rsq; rt_q = tbl[i].rtq;
      step();
      check("tbl_en", i, wr_en, tbl[i].en);
      if (tbl[i].en) begin
        check("tbl_addr", i, wr_addr, tbl[i].addr);
        check("tbl_data", i, wr_data, tbl[i].wdata);
      end
      check("tbl_cnt", i, count, tbl[i].cnt);
      check("tbl_rdy", i, in_ready, tbl[i].rdy);
      check("tbl_rsp", i, rs_pending, exp_pend(tbl[i].rsp));
      check("tbl_rtp", i, rt_pending, exp_pend(tbl[i].rtp));
    end

    // asynchronous reset while a write is in the output stage
    idle_inputs();
    in_valid = 1; regWrite = 1; regDest = 1; rd = 20; writeData = 32'h2020;
    step();
    idle_inputs();
    rs_q = 20;
    step();
    check("mid_en_pre", 0, wr_en, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_en", 0, wr_en, 0);
    check("mid_cnt", 0, count, 0);
    check("mid_rdy", 0, in_ready, 1);
    check("mid_rsp", 0, rs_pending, 0);
    model_reset();
    #2 reset = 1'b0;

`ifdef WB_BYPASS_EN
    idle_inputs();
    wr_stall = 1; in_valid = 1; regWrite = 1; regDest = 1; rd = 3; rs_q = 3;
    writeData = 32'hA; step();
    writeData = 32'hB; step();
    in_valid = 0; step();
    check("byp_fv", 0, rs_fwd_valid, 1);
    check("byp_fd", 0, rs_fwd_data, 32'hB);
    check("byp_pend", 0, rs_pending, 0);
    flush = 1; step();
    flush = 0;
`endif

    // random traffic against the queue model
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      regWrite  = ($urandom_range(0, 9) < 8);
      regDest   = $urandom_range(0, 1);
      rt        = 5'($urandom_range(0, 7));
      rd        = 5'($urandom_range(0, 7));
      writeData = $urandom;
      wr_stall  = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 99) < 3);
      rs_q      = 5'($urandom_range(0, 7));
      rt_q      = 5'($urandom_range(0, 7));
      step();
      model_compare(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
